// File: rtl/prng_arb_pkg.sv
// Shared constants for the PRNG request arbiter: FSM encoding and word/byte geometry.
package prng_arb_pkg;

  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] ISSUE   = 2'b01;
  localparam logic [1:0] COLLECT = 2'b10;
  localparam logic [1:0] DELIVER = 2'b11;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTES_PER_WORD * BYTE_W;
  localparam int unsigned CNT_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/prng_rr_pick.sv
// Combinational rotate-priority picker: first set req bit at or above rr_ptr, wrapping upward.
module prng_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   win_idx
);

  logic        found;
  int unsigned pos;

  always_comb begin
    winner  = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      pos = 32'(rr_ptr) + i;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (!found && req[IDX_W'(pos)]) begin
        found                 = 1'b1;
        win_idx               = IDX_W'(pos);
        winner[IDX_W'(pos)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/prng_arbiter.sv
// Round-robin arbiter sharing one byte-streaming PRNG core; returns 32-bit words to requesters.
// Optional stalled-core abort (rand_err) is built only when PRNG_ARB_TIMEOUT_EN is defined.
module prng_arbiter
  import prng_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
`ifdef PRNG_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = 15
`endif
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [WORD_W-1:0]  rand_data,
  output logic               rand_err,
  output logic               prng_get,
  input  logic [BYTE_W-1:0]  prng_data,
  input  logic               prng_valid
);

  localparam int unsigned IDX_W     = $clog2(NUM_REQ);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

  logic [1:0]         state,     state_d;
  logic [NUM_REQ-1:0] grant,     grant_d;
  logic [IDX_W-1:0]   grant_idx, grant_idx_d;
  logic [IDX_W-1:0]   rr_ptr,    rr_ptr_d;
  logic [CNT_W-1:0]   byte_cnt,  byte_cnt_d;
  logic [WORD_W-1:0]  rand_data_d;
  logic [NUM_REQ-1:0] ack_d;
  logic               prng_get_d;
  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;

`ifdef PRNG_ARB_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_d;
  logic             rand_err_d;
`endif

  prng_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (pick_onehot),
    .win_idx (pick_idx)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      grant     <= '0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      byte_cnt  <= '0;
      rand_data <= '0;
      ack       <= '0;
      prng_get  <= 1'b0;
`ifdef PRNG_ARB_TIMEOUT_EN
      tmo_cnt   <= '0;
      rand_err  <= 1'b0;
`endif
    end else begin
      state     <= state_d;
      grant     <= grant_d;
      grant_idx <= grant_idx_d;
      rr_ptr    <= rr_ptr_d;
      byte_cnt  <= byte_cnt_d;
      rand_data <= rand_data_d;
      ack       <= ack_d;
      prng_get  <= prng_get_d;
`ifdef PRNG_ARB_TIMEOUT_EN
      tmo_cnt   <= tmo_cnt_d;
      rand_err  <= rand_err_d;
`endif
    end
  end

  // Pulses (prng_get, ack) are computed one cycle early so they land in ISSUE/DELIVER.
  always_comb begin
    state_d     = state;
    grant_d     = grant;
    grant_idx_d = grant_idx;
    rr_ptr_d    = rr_ptr;
    byte_cnt_d  = byte_cnt;
    rand_data_d = rand_data;
    ack_d       = '0;
    prng_get_d  = 1'b0;
`ifdef PRNG_ARB_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt;
    rand_err_d  = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (|req) begin
          grant_d     = pick_onehot;
          grant_idx_d = pick_idx;
          prng_get_d  = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // Clear the word so bytes never delivered read as zero.
        byte_cnt_d  = '0;
        rand_data_d = '0;
`ifdef PRNG_ARB_TIMEOUT_EN
        tmo_cnt_d   = TMO_W'(1);
`endif
        state_d     = COLLECT;
      end
      COLLECT: begin
        if (prng_valid) begin
          rand_data_d[BYTE_W*byte_cnt +: BYTE_W] = prng_data;
          byte_cnt_d = byte_cnt + 1'b1;
        end
        if (prng_valid && (byte_cnt == LAST_BYTE)) begin
          ack_d   = grant;
          state_d = DELIVER;
        end
`ifdef PRNG_ARB_TIMEOUT_EN
        else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
          ack_d      = grant;
          rand_err_d = 1'b1;
          byte_cnt_d = '0;
          state_d    = DELIVER;
        end else begin
          tmo_cnt_d = tmo_cnt + 1'b1;
        end
`endif
      end
      DELIVER: begin
        rr_ptr_d = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifndef PRNG_ARB_TIMEOUT_EN
  assign rand_err = 1'b0;
`endif

endmodule

// File: tb/tb_prng_arbiter.sv
// Self-checking bench for prng_arbiter: transaction-level reference model plus directed/random stimulus.
module tb_prng_arbiter;

  localparam int N       = 4;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] req;
  logic [N-1:0] ack;
  logic [31:0]  rand_data;
  logic         rand_err;
  logic         prng_get;
  logic [7:0]   prng_data;
  logic         prng_valid;

  always #5 clk = ~clk;

  prng_arbiter #(.NUM_REQ(N)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req        (req),
    .ack        (ack),
    .rand_data  (rand_data),
    .rand_err   (rand_err),
    .prng_get   (prng_get),
    .prng_data  (prng_data),
    .prng_valid (prng_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- PRNG core model: 4 consecutive bytes per prng_get ----------------
  int         core_mode;  // 0 random bytes/gap, 1 fixed CD 8A 46 02, 2 short AA BB only
  logic [7:0] cbytes [4];
  int         c_left, c_gap, c_idx;

  initial begin
    prng_valid = 1'b0;
    prng_data  = 8'h00;
    c_left = 0; c_gap = 0; c_idx = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rstn) begin
        c_left     = 0;
        prng_valid = 1'b0;
      end else begin
        if (c_left > 0 && c_gap == 0) begin
          prng_valid = 1'b1;
          prng_data  = cbytes[c_idx];
          c_idx++;
          c_left--;
        end else begin
          // Stray bytes while no word is pending must be ignored by the arbiter.
          prng_valid = (core_mode == 0 && c_left == 0) ? ($urandom_range(0, 7) == 0) : 1'b0;
          prng_data  = 8'($urandom);
          if (c_left > 0 && c_gap > 0) c_gap--;
        end
        if (prng_get === 1'b1) begin
          c_idx = 0;
          if (core_mode == 1) begin
            cbytes[0] = 8'hCD; cbytes[1] = 8'h8A; cbytes[2] = 8'h46; cbytes[3] = 8'h02;
            c_left = 4; c_gap = 0;
          end else if (core_mode == 2) begin
            cbytes[0] = 8'hAA; cbytes[1] = 8'hBB; cbytes[2] = 8'h00; cbytes[3] = 8'h00;
            c_left = 2; c_gap = 0;
          end else begin
            for (int i = 0; i < 4; i++) cbytes[i] = 8'($urandom);
            c_left = 4; c_gap = $urandom_range(0, 3);
          end
        end
      end
    end
  end

  // ---------------- Reference model and per-cycle compare ----------------
  int          cyc = 0;
  int          get_cnt = 0;
  int          ack_cnt = 0;
  bit          m_busy = 0;
  int          m_ptr = 0, m_free = 0, m_get = 0, m_ack = -1, m_nb = 0, m_win = 0;
  logic [31:0] m_word = '0;
  logic        m_err = 1'b0;
  logic        exp_get;
  logic [N-1:0] exp_ack;

  always @(negedge clk) begin
    cyc++;
    if (prng_get === 1'b1) get_cnt++;
    if (ack !== '0) ack_cnt++;
    if (!rstn) begin
      chk("reset_ctrl", 32'({ack, rand_err, prng_get}), 32'h0);
      chk("reset_data", rand_data, 32'h0);
      m_busy = 0; m_ptr = 0; m_free = 0; m_ack = -1;
    end else begin
      exp_get = m_busy && (cyc == m_get);
      exp_ack = (m_busy && cyc == m_ack) ? 4'(1 << m_win) : '0;
      chk("prng_get", 32'(prng_get), 32'(exp_get));
      chk("ack", 32'(ack), 32'(exp_ack));
      if (exp_ack != '0) begin
        chk("rand_data", rand_data, m_word);
        chk("rand_err", 32'(rand_err), 32'(m_err));
        m_busy = 0;
        m_ptr  = (m_win + 1) % N;
        m_free = cyc + 1;
      end else if (m_busy && m_ack < 0 && cyc > m_get) begin
        if (prng_valid === 1'b1) begin
          m_word = m_word | (32'(prng_data) << (8 * m_nb));
          m_nb++;
          if (m_nb == 4) m_ack = cyc + 1;
        end
`ifdef PRNG_ARB_TIMEOUT_EN
        if (m_ack < 0 && cyc == m_get + TIMEOUT - 1) begin
          m_ack = cyc + 1;
          m_err = 1'b1;
        end
`endif
      end
      if (!m_busy && cyc >= m_free && req != '0) begin
        for (int i = 0; i < N; i++) begin
          if (req[2'((m_ptr + i) % N)]) begin
            m_win = (m_ptr + i) % N;
            break;
          end
        end
        m_busy = 1; m_get = cyc + 1; m_ack = -1; m_nb = 0; m_word = '0; m_err = 1'b0;
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  task automatic wait_ack(input int bound, output logic [N-1:0] a, output logic [31:0] d,
                          output logic e, output int at);
    a = '0; d = '0; e = 1'b0; at = -1;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (ack !== '0) begin
        a = ack; d = rand_data; e = rand_err; at = k;
        break;
      end
    end
    if (at < 0) begin
      total++; bad++;
      $display("FAIL ack_wait: no ack within %0d cycles", bound);
    end
  endtask

  task automatic wait_get(input int bound);
    bit seen;
    seen = 0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      if (prng_get === 1'b1) begin seen = 1; break; end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL get_wait: no prng_get within %0d cycles", bound);
    end
  endtask

  task automatic do_reset(input int n);
    rstn = 1'b0;
    repeat (n) tick();
    rstn = 1'b1;
  endtask

  logic [N-1:0] a;
  logic [31:0]  d;
  logic         e;
  int           at, g0, n0, nb;

  initial begin
    rstn = 1'b1; req = '0; core_mode = 0;
    #1 rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    tick();

    // Single request, fixed bytes
    core_mode = 1; g0 = get_cnt; req = 4'b0001;
    wait_ack(40, a, d, e, at);
    chk("single_ack", 32'(a), 32'h1);
    chk("single_data", d, 32'h02468ACD);
    chk("single_err", 32'(e), 32'h0);
    chk("single_latency", 32'(at), 32'd6);
    tick(); req = '0;
    chk("single_gets", 32'(get_cnt - g0), 32'd1);

    // All requesters held: strict rotation from requester 0
    do_reset(2);
    core_mode = 0; g0 = get_cnt; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_ack(40, a, d, e, at);
      chk($sformatf("all_ack%0d", i), 32'(a), 32'(1 << (i % 4)));
    end
    tick(); req = '0;
    chk("all_gets", 32'(get_cnt - g0), 32'd5);

    // Wrap priority after serving requester 2
    req = 4'b0100;
    wait_ack(40, a, d, e, at); chk("wrap_a", 32'(a), 32'h4);
    tick(); req = 4'b1011;
    wait_ack(40, a, d, e, at); chk("wrap_b", 32'(a), 32'h8);
    tick(); req = 4'b0011;
    wait_ack(40, a, d, e, at); chk("wrap_c", 32'(a), 32'h1);
    tick(); req = 4'b0010;
    wait_ack(40, a, d, e, at); chk("wrap_d", 32'(a), 32'h2);
    tick(); req = '0;

    // Withdrawn request is still served
    g0 = get_cnt; req = 4'b0010;
    wait_get(20);
    tick(); req = '0;
    wait_ack(40, a, d, e, at); chk("withdrawn_ack", 32'(a), 32'h2);
    repeat (10) tick();
    chk("withdrawn_gets", 32'(get_cnt - g0), 32'd1);

    // Randomized traffic
    n0 = ack_cnt;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      a = ack;
      tick();
      for (int b = 0; b < N; b++) begin
        if (req[b]) begin
          if (a[b] && $urandom_range(0, 1) == 0) req[b] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[b] = 1'b1;
        end
      end
    end
    req = '0;
    repeat (30) tick();
    chk("random_progress", 32'(ack_cnt - n0 > 50), 32'h1);

    // Reset in the middle of COLLECT
    core_mode = 1; req = 4'b0001;
    wait_get(20);
    nb = 0;
    for (int k = 0; k < 20 && nb < 2; k++) begin
      @(negedge clk);
      if (prng_valid === 1'b1) nb++;
    end
    tick();
    rstn = 1'b0; req = 4'b0100;
    @(negedge clk);
    chk("midrst_data", rand_data, 32'h0);
    chk("midrst_ctrl", 32'({ack, rand_err, prng_get}), 32'h0);
    tick(); tick();
    n0 = ack_cnt;
    rstn = 1'b1;
    wait_ack(40, a, d, e, at);
    chk("midrst_ack", 32'(a), 32'h4);
    chk("midrst_word", d, 32'h02468ACD);
    chk("midrst_latency", 32'(at), 32'd6);
    tick(); req = '0;

    // Core stalls after two bytes
    core_mode = 2; req = 4'b0001;
`ifdef PRNG_ARB_TIMEOUT_EN
    wait_ack(40, a, d, e, at);
    chk("tmo_ack", 32'(a), 32'h1);
    chk("tmo_err", 32'(e), 32'h1);
    chk("tmo_data", d, 32'h0000BBAA);
    chk("tmo_latency", 32'(at), 32'd16);
    tick(); req = '0;
`else
    n0 = ack_cnt;
    repeat (40) tick();
    chk("stall_no_ack", 32'(ack_cnt - n0), 32'h0);
    req = '0;
    do_reset(2);
`endif

    // Recovery
    core_mode = 0; req = 4'b0010;
    wait_ack(40, a, d, e, at);
    chk("final_ack", 32'(a), 32'h2);
    chk("final_err", 32'(e), 32'h0);
    tick(); req = '0;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
